// File: rtl/mydemux_10bit_reg_pkg.sv
// Shared constants and types for the registered 1:2 word demultiplexer.
// Holds the default widths, the channel select encoding and the slot state type.
package mydemux_10bit_reg_pkg;

   localparam int DATA_W_DEF = 10;
   localparam int CNT_W_DEF  = 8;

   localparam logic CH1 = 1'b0;
   localparam logic CH2 = 1'b1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

endpackage

// File: rtl/mydemux_slot.sv
// Single-entry valid/ready holding register feeding one output channel.
// Optional per-slot accept counter is built only when MYDEMUX_COUNT_EN is defined.
module mydemux_slot
   import mydemux_10bit_reg_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              accept,
   input  logic [DATA_W-1:0] word,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   input  logic              ready,
   output logic              room,
   output logic [CNT_W-1:0]  count
);

   slot_state_t state;
   slot_state_t state_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // An accept always wins, so a drain and refill in one cycle keeps the slot full.
   always_comb begin
      state_next = state;
      if (accept) begin
         state_next = FULL;
      end else if (state == FULL && ready) begin
         state_next = EMPTY;
      end
   end

   assign valid = (state == FULL);
   assign room  = (state == EMPTY) || ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data <= '0;
      end else if (accept) begin
         data <= word;
      end
   end

`ifdef MYDEMUX_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (accept) begin
         count <= count + 1'b1;
      end
   end
`else
   assign count = '0;
`endif

endmodule

// File: rtl/mydemux_10bit_reg.sv
// Registered 1:2 demultiplexer: steers each accepted word into one of two slots.
// Per-channel word counters are present only when MYDEMUX_COUNT_EN is defined.
module mydemux_10bit_reg
   import mydemux_10bit_reg_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_select,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out1_data,
   output logic              out1_valid,
   input  logic              out1_ready,
   output logic [DATA_W-1:0] out2_data,
   output logic              out2_valid,
   input  logic              out2_ready,
   output logic [CNT_W-1:0]  out1_count,
   output logic [CNT_W-1:0]  out2_count
);

   logic room1;
   logic room2;
   logic accept1;
   logic accept2;

   // Readiness depends only on the addressed slot, so a stalled channel never blocks the other.
   assign in_ready = (in_select == CH1) ? room1 : room2;
   assign accept1  = in_valid && in_ready && (in_select == CH1);
   assign accept2  = in_valid && in_ready && (in_select == CH2);

   mydemux_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) slot1 (
      .clk    (clk),
      .rst    (rst),
      .accept (accept1),
      .word   (in_data),
      .data   (out1_data),
      .valid  (out1_valid),
      .ready  (out1_ready),
      .room   (room1),
      .count  (out1_count)
   );

   mydemux_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) slot2 (
      .clk    (clk),
      .rst    (rst),
      .accept (accept2),
      .word   (in_data),
      .data   (out2_data),
      .valid  (out2_valid),
      .ready  (out2_ready),
      .room   (room2),
      .count  (out2_count)
   );

endmodule
